// File: rtl/encoder_tracker.sv
// Absolute-encoder tracker: samples a 7-bit position every SAMPLE_DIV clocks, unwraps it into a
// signed multi-turn count, and faults on repeated bad samples. Optional velocity: ENC_VELOCITY_EN.
module encoder_tracker #(
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned MAX_STEP   = 8,
  parameter int unsigned ERR_LIMIT  = 3,
  parameter int unsigned VEL_WINDOW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pos_in,
  input  logic        clr,
  output logic [7:0]  position,
  output logic        pos_valid,
  output logic [15:0] count,
  output logic        dir,
  output logic        step_err,
  output logic        fault,
  output logic [11:0] velocity,
  output logic        vel_valid
);

  localparam int unsigned PS_W    = 16;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned DELTA_W = 7;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned VEL_W   = 12;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state;
  logic [PS_W-1:0]    ps_cnt;
  logic [ERR_W-1:0]   err_cnt;

  logic               tick_c;
  logic [DELTA_W-1:0] delta_c;
  logic [DELTA_W-1:0] delta_mag_c;
  logic [CNT_W-1:0]   delta_ext_c;
  logic               bad_c;
  logic [ERR_W-1:0]   err_next_c;
  logic               fault_hit_c;

  // Delta is taken modulo 128 so crossing the 127/0 seam reads as a small step.
  assign tick_c      = (ps_cnt == PS_W'(SAMPLE_DIV - 1));
  assign delta_c     = pos_in[DELTA_W-1:0] - position[DELTA_W-1:0];
  assign delta_mag_c = delta_c[DELTA_W-1] ? DELTA_W'(-delta_c) : delta_c;
  assign delta_ext_c = {{(CNT_W-DELTA_W){delta_c[DELTA_W-1]}}, delta_c};
  assign bad_c       = pos_in[7] ||
                       ((state == ST_TRACK) && (delta_mag_c > DELTA_W'(MAX_STEP)));
  assign err_next_c  = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
  assign fault_hit_c = (32'(err_next_c) >= ERR_LIMIT);

  // Sample prescaler; clr restarts the sample phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (clr || tick_c) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Tracking state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      position  <= '0;
      pos_valid <= 1'b0;
      count     <= '0;
      dir       <= 1'b0;
      step_err  <= 1'b0;
      fault     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      step_err <= 1'b0;
      if (clr) begin
        state     <= ST_INIT;
        count     <= '0;
        err_cnt   <= '0;
        fault     <= 1'b0;
        pos_valid <= 1'b0;
      end else if (tick_c) begin
        case (state)
          ST_INIT, ST_TRACK: begin
            if (bad_c) begin
              step_err <= 1'b1;
              err_cnt  <= err_next_c;
              if (fault_hit_c) begin
                state     <= ST_FAULT;
                fault     <= 1'b1;
                pos_valid <= 1'b0;
              end
            end else if (state == ST_INIT) begin
              state     <= ST_TRACK;
              position  <= pos_in;
              count     <= '0;
              pos_valid <= 1'b1;
              err_cnt   <= '0;
            end else begin
              position <= pos_in;
              count    <= count + delta_ext_c;
              err_cnt  <= '0;
              if (delta_c != '0) begin
                dir <= ~delta_c[DELTA_W-1];
              end
            end
          end
          ST_FAULT: begin
            state <= ST_FAULT;
          end
          default: begin
            state <= ST_INIT;
          end
        endcase
      end
    end
  end

`ifdef ENC_VELOCITY_EN
  localparam int unsigned WIN_W = 6;

  logic [WIN_W-1:0] win_cnt;
  logic [VEL_W-1:0] vel_acc;
  logic [VEL_W-1:0] vel_add_c;

  // Only accepted TRACK deltas contribute; rejected ticks still advance the window.
  assign vel_add_c = ((state == ST_TRACK) && !bad_c) ?
                     {{(VEL_W-DELTA_W){delta_c[DELTA_W-1]}}, delta_c} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      vel_acc   <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (clr) begin
        win_cnt  <= '0;
        vel_acc  <= '0;
        velocity <= '0;
      end else if (tick_c && (state != ST_FAULT)) begin
        if (win_cnt == WIN_W'(VEL_WINDOW - 1)) begin
          velocity  <= vel_acc + vel_add_c;
          vel_valid <= 1'b1;
          vel_acc   <= '0;
          win_cnt   <= '0;
        end else begin
          vel_acc <= vel_acc + vel_add_c;
          win_cnt <= win_cnt + WIN_W'(1);
        end
      end
    end
  end
`else
  logic unused_vel_window;

  assign velocity          = '0;
  assign vel_valid         = 1'b0;
  assign unused_vel_window = (VEL_WINDOW != 0);
`endif

endmodule
